rst_key_ctrl: RTL and testbench

Parametrised reset sequencer and multi-channel key debouncer for the j1 SoC top. It stretches the board reset into a clean synchronous core reset of configurable length. It also debounces KEY_NUM push-buttons into levels, press/release pulses and wrapping press counters. This replaces the fixed 4-bit reset counter and the ad-hoc single-key debounce logic in the top level. The CPU consumes rst_out and key_press (e.g. CPU-select stepping).

---
 rtl/rst_key_ctrl.sv | 170 +++++++++++++++++
 tb/tb_rst_key_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_key_ctrl.sv
// Reset sequencer plus KEY_NUM-channel push-button debouncer for the j1 SoC top.
// Produces a stretched synchronous-release core reset and debounced key levels, pulses and press counts.
module rst_key_ctrl #(
  parameter int unsigned RST_CYCLES      = 15,
  parameter int unsigned KEY_NUM         = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned KEY_ACTIVE_LOW  = 1,
  parameter int unsigned CNT_W           = 8
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic [KEY_NUM-1:0]       key_in,
  input  logic [KEY_NUM-1:0]       cnt_clr,
  output logic                     rst_out,
  output logic [KEY_NUM-1:0]       key_level,
  output logic [KEY_NUM-1:0]       key_press,
  output logic [KEY_NUM-1:0]       key_release,
  output logic [KEY_NUM*CNT_W-1:0] press_cnt
);

  localparam int unsigned RCW = $clog2(RST_CYCLES + 1);
  localparam int unsigned DW  = $clog2(DEBOUNCE_CYCLES);
  // Raw pin level that means "not pressed"; synchronisers reset to it.
  localparam logic KEY_IDLE = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    K_IDLE,
    K_PRESS_WAIT,
    K_PRESSED,
    K_RELEASE_WAIT
  } key_state_e;

  // Reset sequencer
  logic [1:0]     rsync_q;
  logic [RCW-1:0] rcnt_q, rcnt_d;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      rsync_q <= '0;
      rcnt_q  <= RCW'(RST_CYCLES);
    end else begin
      rsync_q <= {rsync_q[0], 1'b1};
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    if (!rsync_q[1]) begin
      rcnt_d = RCW'(RST_CYCLES);
    end else if (rcnt_q != '0) begin
      rcnt_d = rcnt_q - RCW'(1);
    end else begin
      rcnt_d = '0;
    end
  end

  // Key channels
  logic [KEY_NUM-1:0] ksync0_q, ksync1_q;
  logic [KEY_NUM-1:0] key_s;
  logic [KEY_NUM-1:0] differ, expire;

  key_state_e         state_q [KEY_NUM];
  key_state_e         state_d [KEY_NUM];
  logic [DW-1:0]      dcnt_q  [KEY_NUM];
  logic [DW-1:0]      dcnt_d  [KEY_NUM];
  logic [CNT_W-1:0]   pcnt_q  [KEY_NUM];
  logic [CNT_W-1:0]   pcnt_d  [KEY_NUM];
  logic [KEY_NUM-1:0] press_q, press_d;
  logic [KEY_NUM-1:0] release_q, release_d;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      ksync0_q <= {KEY_NUM{KEY_IDLE}};
      ksync1_q <= {KEY_NUM{KEY_IDLE}};
    end else begin
      ksync0_q <= key_in;
      ksync1_q <= ksync0_q;
    end
  end

  // State register; debounce state is also held cleared while the core reset is active.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < KEY_NUM; i++) begin
        state_q[i] <= K_IDLE;
        dcnt_q[i]  <= '0;
        pcnt_q[i]  <= '0;
      end
      press_q   <= '0;
      release_q <= '0;
    end else if (rst_out) begin
      for (int unsigned i = 0; i < KEY_NUM; i++) begin
        state_q[i] <= K_IDLE;
        dcnt_q[i]  <= '0;
        pcnt_q[i]  <= '0;
      end
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int unsigned i = 0; i < KEY_NUM; i++) begin
        state_q[i] <= state_d[i];
        dcnt_q[i]  <= dcnt_d[i];
        pcnt_q[i]  <= pcnt_d[i];
      end
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    key_s  = ksync1_q ^ {KEY_NUM{KEY_IDLE}};
    differ = '0;
    expire = '0;
    for (int unsigned i = 0; i < KEY_NUM; i++) begin
      differ[i] = key_s[i] != key_level[i];
      expire[i] = dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1);
    end
  end

  // Next-state logic
  always_comb begin
    press_d   = '0;
    release_d = '0;
    for (int unsigned i = 0; i < KEY_NUM; i++) begin
      state_d[i] = state_q[i];
      dcnt_d[i]  = (differ[i] && !expire[i]) ? dcnt_q[i] + DW'(1) : '0;
      // The counter consumes the previous cycle's press pulse, so clear+press yields 1.
      pcnt_d[i]  = (cnt_clr[i] ? '0 : pcnt_q[i]) + CNT_W'(press_q[i]);
      case (state_q[i])
        K_IDLE: begin
          if (key_s[i]) state_d[i] = K_PRESS_WAIT;
        end
        K_PRESS_WAIT: begin
          if (!key_s[i]) begin
            state_d[i] = K_IDLE;
          end else if (expire[i]) begin
            state_d[i] = K_PRESSED;
            press_d[i] = 1'b1;
          end
        end
        K_PRESSED: begin
          if (!key_s[i]) state_d[i] = K_RELEASE_WAIT;
        end
        K_RELEASE_WAIT: begin
          if (key_s[i]) begin
            state_d[i] = K_PRESSED;
          end else if (expire[i]) begin
            state_d[i]   = K_IDLE;
            release_d[i] = 1'b1;
          end
        end
        default: state_d[i] = K_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    rst_out     = !rsync_q[1] || (rcnt_q != '0);
    key_level   = '0;
    press_cnt   = '0;
    for (int unsigned i = 0; i < KEY_NUM; i++) begin
      key_level[i] = (state_q[i] == K_PRESSED) || (state_q[i] == K_RELEASE_WAIT);
      press_cnt[i*CNT_W +: CNT_W] = pcnt_q[i];
    end
    key_press   = press_q;
    key_release = release_q;
  end

endmodule

// File: tb/tb_rst_key_ctrl.sv
// Scoreboard bench for rst_key_ctrl: a cycle-level reference model queues expected
// snapshots and key events; a negedge monitor pops and compares them against the DUT.
module tb_rst_key_ctrl;
  localparam int RST = 4;
  localparam int KN  = 2;
  localparam int DB  = 8;
  localparam int AL  = 1;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_in;
  logic [KN-1:0] key_in;
  logic [KN-1:0] cnt_clr;
  logic          rst_out;
  logic [KN-1:0] key_level, key_press, key_release;
  logic [KN*CW-1:0] press_cnt;

  always #5 clk = ~clk;

  rst_key_ctrl #(
    .RST_CYCLES(RST),
    .KEY_NUM(KN),
    .DEBOUNCE_CYCLES(DB),
    .KEY_ACTIVE_LOW(AL),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_in(rst_in),
    .key_in(key_in),
    .cnt_clr(cnt_clr),
    .rst_out(rst_out),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .press_cnt(press_cnt)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit started     = 0;

  typedef struct {
    logic             ro;
    logic [KN-1:0]    lvl;
    logic [KN*CW-1:0] cnt;
  } snap_t;

  typedef struct {
    int cyc;
    int key;
    bit rel;
  } ev_t;

  snap_t snapq[$];
  ev_t   evq[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  // Reference model: edges since release, a 2-deep sample delay per key, and a
  // run length of cycles the delayed key differs from the accepted level.
  int rel_edges = 0;
  bit m_ro = 1'b1;
  bit m_lvl [KN];
  int m_run [KN];
  int m_cnt [KN];
  bit m_pr  [KN];
  bit m_s0  [KN];
  bit m_s1  [KN];

  always @(posedge clk) begin : model
    snap_t sn;
    ev_t   ev;
    bit    ro_prev;
    cyc++;
    ro_prev = m_ro;
    if (!rst_in) begin
      rel_edges = 0;
      m_ro = 1'b1;
      for (int i = 0; i < KN; i++) begin
        m_lvl[i] = 0; m_run[i] = 0; m_cnt[i] = 0; m_pr[i] = 0; m_s0[i] = 0; m_s1[i] = 0;
      end
    end else begin
      rel_edges++;
      for (int i = 0; i < KN; i++) begin
        if (ro_prev) begin
          m_lvl[i] = 0; m_run[i] = 0; m_cnt[i] = 0; m_pr[i] = 0;
        end else begin
          m_cnt[i] = ((cnt_clr[i] ? 0 : m_cnt[i]) + (m_pr[i] ? 1 : 0)) % (1 << CW);
          m_pr[i] = 0;
          if (m_s1[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
              m_lvl[i] = !m_lvl[i];
              m_run[i] = 0;
              m_pr[i]  = m_lvl[i];
              ev.cyc = cyc; ev.key = i; ev.rel = !m_lvl[i];
              evq.push_back(ev);
            end
          end else begin
            m_run[i] = 0;
          end
        end
        m_s1[i] = m_s0[i];
        m_s0[i] = (AL != 0) ? !key_in[i] : key_in[i];
      end
      m_ro = rel_edges < 2 + RST;
    end
    sn.ro = m_ro;
    for (int i = 0; i < KN; i++) begin
      sn.lvl[i] = m_lvl[i];
      sn.cnt[i*CW +: CW] = CW'(m_cnt[i]);
    end
    snapq.push_back(sn);
    started = 1;
  end

  always @(negedge clk) begin : monitor
    snap_t ex;
    bit    pulse;
    bit    found;
    if (started) begin
      if (snapq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL snapshot_queue @cyc %0d: got empty expected entry", cyc);
      end else begin
        ex = snapq.pop_front();
        if (!rst_in) begin
          ex.ro = 1'b1; ex.lvl = '0; ex.cnt = '0;
          while (evq.size() > 0 && evq[$].cyc == cyc) void'(evq.pop_back());
        end
        chk("rst_out", rst_out, ex.ro);
        chk("key_level", key_level, ex.lvl);
        chk("press_cnt", press_cnt, ex.cnt);
      end
      for (int i = 0; i < KN; i++) begin
        for (int k = 0; k < 2; k++) begin
          pulse = (k == 0) ? key_press[i] : key_release[i];
          if (pulse) begin
            found = 0;
            for (int j = 0; j < evq.size(); j++) begin
              if (!found && evq[j].cyc == cyc && evq[j].key == i && evq[j].rel == (k == 1)) begin
                evq.delete(j);
                found = 1;
              end
            end
            vectors++;
            if (!found) begin
              miscompares++;
              $display("FAIL unexpected_%s key %0d @cyc %0d: got pulse expected none",
                       (k == 0) ? "press" : "release", i, cyc);
            end
          end
        end
      end
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        vectors++; miscompares++;
        $display("FAIL missing_%s key %0d @cyc %0d: got no pulse expected pulse",
                 evq[0].rel ? "release" : "press", evq[0].key, evq[0].cyc);
        void'(evq.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press0();
    key_in[0] = 1'b0; tick(12);
    key_in[0] = 1'b1; tick(12);
  endtask

  initial begin
    rst_in  = 1'b0;
    key_in  = 2'b11;
    cnt_clr = 2'b00;

    // Reset release
    tick(3);
    rst_in = 1'b1;
    tick(12);

    // Clean press and release on key 0
    key_in[0] = 1'b0; tick(20);
    key_in[0] = 1'b1; tick(20);

    // Bounce on key 1, then one stable press
    repeat (4) begin
      key_in[1] = 1'b0; tick(5);
      key_in[1] = 1'b1; tick(1);
    end
    tick(12);
    key_in[1] = 1'b0; tick(12);
    key_in[1] = 1'b1; tick(14);

    // Wrap of key 0 counter
    cnt_clr[0] = 1'b1; tick(1); cnt_clr[0] = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      press0();
      if (n >= 15) begin
        @(negedge clk);
        chk("press_cnt0_wrap", press_cnt[CW-1:0], n % 16);
        tick(1);
      end
    end
    press0();
    press0();

    // Clear coincident with a press pulse
    key_in[0] = 1'b0; tick(10);
    cnt_clr[0] = 1'b1; tick(1); cnt_clr[0] = 1'b0;
    @(negedge clk);
    chk("press_cnt0_clr_and_press", press_cnt[CW-1:0], 1);
    tick(1);
    key_in[0] = 1'b1; tick(12);

    // Clear of key 1 alone
    @(negedge clk);
    chk("press_cnt1_before_clr", press_cnt[2*CW-1:CW], 1);
    tick(1);
    cnt_clr[1] = 1'b1; tick(1); cnt_clr[1] = 1'b0;
    @(negedge clk);
    chk("press_cnt1_clr", press_cnt[2*CW-1:CW], 0);
    tick(1);

    // Mid-operation reset with key 0 held
    key_in[0] = 1'b0; tick(12);
    @(negedge clk);
    chk("key_level0_held", key_level[0], 1);
    tick(1);
    rst_in = 1'b0;
    #1;
    chk("rst_out_async", rst_out, 1);
    chk("key_level_async", key_level, 0);
    tick(1);
    rst_in = 1'b1;
    tick(20);
    key_in[0] = 1'b1; tick(14);

    // Simultaneous press on both keys
    key_in = 2'b00; tick(14);
    key_in = 2'b11; tick(14);

    // Randomised traffic
    repeat (200) begin
      key_in  = 2'($urandom_range(0, 3));
      cnt_clr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      tick(1);
      cnt_clr = 2'b00;
      tick($urandom_range(0, 13));
      if ($urandom_range(0, 24) == 0) begin
        rst_in = 1'b0;
        tick($urandom_range(1, 2));
        rst_in = 1'b1;
      end
    end
    key_in = 2'b11;
    tick(30);

    @(negedge clk);
    vectors++;
    if (evq.size() != 0) begin
      miscompares++;
      $display("FAIL event_queue_drain: got %0d pending expected 0", evq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
